data_16x4_readback: RTL
=======================

# data_16x4_readback

Host-readback responder for the 4-byte data path: watches the same UART receive byte stream used by the write path. On a read-command byte, it snapshots four 8-bit data words and streams them back, byte 0 first, to the UART transmitter over a valid/ready byte interface. It sits between the UART RX/TX pair and the systolic-array result registers, and is the read-side counterpart of the 4-byte write loader.

## Interface
- DATA_READ_ADDR, 8'h82, command byte that starts a readback

- Clock  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- uart_rw  in  1  RX byte strobe; byte valid on its rising edge
- uart_in  in  8  RX byte, valid while uart_rw high
- read_data0  in  8  data word 0 (sent first)
- read_data1  in  8  data word 1
- read_data2  in  8  data word 2
- read_data3  in  8  data word 3 (sent last)
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  transmitter accepts byte when tx_valid & tx_ready at a clock edge
- rd_busy  out  1  high from command accept until last byte accepted
- rd_done  out  1  one-cycle pulse after last byte accepted

## Operation
- Edge detect: uart_rw_reg <= uart_rw; rx_en = uart_rw & !uart_rw_reg; uart_rw_reg resets to 0.
- States: IDLE, SEND.
- IDLE: rx_en & (uart_in == DATA_READ_ADDR) -> capture read_data0..3 into shadow regs snap0..3, byte_idx <= 0, -> SEND. Any other byte is ignored.
- SEND: tx_valid = 1, tx_data = snap[byte_idx]. On tx_valid & tx_ready: if byte_idx == last, -> IDLE and pulse rd_done; else byte_idx + 1.
- byte_idx: 3-bit counter, last = 3 (4 with header, see Configuration); no wrap beyond last.
- rx_en during SEND, including a new DATA_READ_ADDR, is ignored. Commands are not queued.
- Changes on read_data* after the snapshot do not affect the bytes being sent.
- tx_data = 8'h00 whenever tx_valid = 0.
- Reset values: tx_data 0, tx_valid 0, rd_busy 0, rd_done 0, state IDLE, byte_idx 0, snap0..3 0.
- Reset asserted mid-transfer aborts immediately: tx_valid drops asynchronously, rd_done does not pulse, and the partial frame is not resumed.

## Timing
- Command byte strobe rising at edge N (rx_en high in cycle before edge N) -> at edge N state=SEND, snapshot taken; tx_valid/rd_busy high from N, tx_data = byte 0.
- tx_valid and tx_data are registered outputs and stay stable until accepted.
- Back-to-back: tx_ready held high -> one byte per cycle, 4 cycles, no bubbles.
- Acceptance of last byte at edge M -> tx_valid/rd_busy low and rd_done high for cycle after M. A command is accepted again from edge M+1.
- tx_ready while tx_valid = 0 has no effect.

## Configuration
- READBACK_HEADER_EN defined: each frame is prefixed with a header byte equal to DATA_READ_ADDR. Frame is 5 bytes: header, snap0..snap3; last index = 4; rd_done after 5th acceptance.
- Not defined: frame is 4 bytes snap0..snap3 with no header.

## Structure
- Shared package sa_uart_pkg: state encoding (IDLE, SEND), default command constants (write 8'h02, read 8'h82), frame-length constants for both header settings.
- One sub-module: uart_strobe_edge (registered rising-edge detector producing rx_en). The write loader also uses it.

## Test plan
- Reset, then read_data = 11,22,33,44, send 8'h82 with tx_ready=1 -> tx_data 11,22,33,44 on 4 consecutive cycles, rd_done pulse once, rd_busy low afterwards.
- Send 8'h02, 8'h55, then 8'h82 -> only 8'h82 starts a frame; no tx_valid before it.
- tx_ready toggled 1-0-0-1… -> each byte held stable while tx_ready=0, no byte skipped or duplicated, same 4-byte order.
- Change read_data0 to 8'hFF after command accept -> frame still carries 8'h11.
- Second 8'h82 during SEND -> ignored; exactly one 4-byte frame and one rd_done.
- Assert rst_n low after byte 1 accepted -> tx_valid 0 immediately, no rd_done. A fresh 8'h82 after reset yields a full frame. With READBACK_HEADER_EN, the frame is 82,11,22,33,44.

Source files
------------

// File: rtl/sa_uart_pkg.sv
// Shared definitions for the systolic-array UART loaders: readback state encoding,
// command bytes, frame lengths and the frame byte selector.
package sa_uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } rd_state_t;

   localparam logic [7:0] DATA_WRITE_ADDR = 8'h02;
   localparam logic [7:0] DATA_READ_ADDR  = 8'h82;

   localparam int unsigned FRAME_LEN_NOHDR = 4;
   localparam int unsigned FRAME_LEN_HDR   = 5;

   // With a header, index 0 carries the command echo and the data words shift up by one.
   function automatic logic [7:0] frame_byte(input logic hdr, input logic [2:0] idx,
                                             input logic [3:0][7:0] words);
      logic [2:0] widx;
      frame_byte = '0;
      if (hdr && idx == 3'd0) begin
         frame_byte = DATA_READ_ADDR;
      end else begin
         widx = hdr ? 3'(idx - 3'd1) : idx;
         if (widx < 3'd4) frame_byte = words[widx[1:0]];
      end
   endfunction

endpackage

// File: rtl/data_16x4_readback_if.sv
// Byte stream from the readback responder to the UART transmitter (valid/ready).
interface data_16x4_readback_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_strobe_edge.sv
// Registered rising-edge detector for the UART RX byte strobe; shared with the write loader.
module uart_strobe_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe,
   output logic rise
);

   logic uart_rw_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) uart_rw_reg <= 1'b0;
      else        uart_rw_reg <= strobe;
   end

   assign rise = strobe & ~uart_rw_reg;

endmodule

// File: rtl/data_16x4_readback.sv
// Readback responder: on DATA_READ_ADDR snapshots four data words and streams them to the TX.
// Define READBACK_HEADER_EN to prefix each frame with the command byte (5-byte frame).
module data_16x4_readback
   import sa_uart_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        uart_rw,
   input  logic [7:0]                  uart_in,
   input  logic [7:0]                  read_data0,
   input  logic [7:0]                  read_data1,
   input  logic [7:0]                  read_data2,
   input  logic [7:0]                  read_data3,
   data_16x4_readback_if.master        tx,
   output logic                        rd_busy,
   output logic                        rd_done
);

`ifdef READBACK_HEADER_EN
   localparam logic        HDR       = 1'b1;
   localparam int unsigned FRAME_LEN = FRAME_LEN_HDR;
`else
   localparam logic        HDR       = 1'b0;
   localparam int unsigned FRAME_LEN = FRAME_LEN_NOHDR;
`endif
   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

   rd_state_t       state, state_next;
   logic [2:0]      byte_idx, idx_next;
   logic [3:0][7:0] snap;
   logic            capture;
   logic            accept;
   logic            rx_en;
   logic            valid_next;
   logic [7:0]      data_next;
   logic            done_next;
   logic [3:0][7:0] src_words;

   uart_strobe_edge u_strobe_edge (
      .clk    (clk),
      .rst_n  (rst_n),
      .strobe (uart_rw),
      .rise   (rx_en)
   );

   assign accept  = tx.tx_valid & tx.tx_ready;
   assign rd_busy = (state == SEND);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         byte_idx    <= '0;
         snap        <= '0;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= '0;
         rd_done     <= 1'b0;
      end else begin
         state       <= state_next;
         byte_idx    <= idx_next;
         if (capture) snap <= {read_data3, read_data2, read_data1, read_data0};
         tx.tx_valid <= valid_next;
         tx.tx_data  <= data_next;
         rd_done     <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      idx_next   = byte_idx;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx_en && uart_in == DATA_READ_ADDR) begin
               state_next = SEND;
               idx_next   = '0;
               capture    = 1'b1;
            end
         end
         SEND: begin
            if (accept) begin
               if (byte_idx == LAST_IDX) begin
                  state_next = IDLE;
                  idx_next   = '0;
               end else begin
                  idx_next = 3'(byte_idx + 3'd1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from next-cycle values, so the first byte comes straight
   // from the live inputs on the capture edge rather than from the snapshot.
   always_comb begin
      src_words  = capture ? {read_data3, read_data2, read_data1, read_data0} : snap;
      valid_next = (state_next == SEND);
      data_next  = valid_next ? frame_byte(HDR, idx_next, src_words) : '0;
      done_next  = (state == SEND) && accept && (byte_idx == LAST_IDX);
   end

endmodule
